// File: rtl/idct_2d.sv
// Inverse 8x8 2-D DCT: one coefficient block in, one level-shifted pixel block out.
// Each CALC cycle sums all 64 weighted coefficients for a single pixel (x,y).
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   start_block   request to start a block, sampled only in IDLE
//   coef_block    dequantized coefficients C(u,v), signed Q16.0, latched on accept
//   pix_block_out reconstructed pixels f(x,y), signed Q9.0, written one per cycle
//   busy          high while a block is being computed or completed (CALC, DONE)
//   block_done    one-cycle pulse once all 64 pixels of the block are valid
module idct_2d #(
    parameter int BLOCK_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_block,
    input  logic signed [15:0] coef_block    [0:BLOCK_SIZE-1][0:BLOCK_SIZE-1],
    output logic signed [8:0]  pix_block_out [0:BLOCK_SIZE-1][0:BLOCK_SIZE-1],
    output logic               busy,
    output logic               block_done
);

    localparam int N = BLOCK_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]         r_x;
    logic [2:0]         r_y;
    logic signed [15:0] r_coef [0:N-1][0:N-1];
    logic signed [8:0]  r_pix  [0:N-1][0:N-1];

    logic signed [59:0] w_acc;
    logic signed [59:0] w_rnd;
    logic signed [59:0] w_shf;
    logic signed [8:0]  w_pix;
    logic               w_accept;
    logic               w_last;

    // Basis normalisation, Q1.8 unsigned: 1/sqrt(8) for DC, 1/2 otherwise.
    function automatic logic [8:0] alpha(input logic [2:0] k);
        return (k == 3'd0) ? 9'd91 : 9'd128;
    endfunction

    // round(256*cos((2n+1)k*pi/16)), Q2.8 signed.
    // The angle index is reduced mod 32 (full turn), folded into
    // [0,16] by symmetry about pi, then into [0,8] with a sign flip.
    function automatic logic signed [9:0] cos_q8(
        input logic [2:0] n,
        input logic [2:0] k
    );
        logic [4:0] m;
        logic [3:0] f;
        logic       neg;
        logic [8:0] mag;
        m = {1'b0, n, 1'b1} * {2'b00, k};
        if (m > 5'd16) begin
            m = 5'(6'd32 - {1'b0, m});
        end
        neg = (m > 5'd8);
        f   = neg ? 4'(5'd16 - m) : m[3:0];
        case (f)
            4'd0:    mag = 9'd256;
            4'd1:    mag = 9'd251;
            4'd2:    mag = 9'd237;
            4'd3:    mag = 9'd213;
            4'd4:    mag = 9'd181;
            4'd5:    mag = 9'd142;
            4'd6:    mag = 9'd98;
            4'd7:    mag = 9'd50;
            default: mag = 9'd0;
        endcase
        return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    // a(u)*a(v)*C(u,v)*cos[x][u]*cos[y][v], Q20.32.
    // Alphas are zero-extended so 128 stays positive.
    function automatic logic signed [59:0] term(
        input logic signed [15:0] c,
        input logic        [8:0]  au,
        input logic        [8:0]  av,
        input logic signed [9:0]  cx,
        input logic signed [9:0]  cy
    );
        logic signed [59:0] t;
        t = 60'(c);
        t = t * 60'($signed({1'b0, au}));
        t = t * 60'($signed({1'b0, av}));
        t = t * 60'(cx);
        t = t * 60'(cy);
        return t;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_accept = (r_state == S_IDLE) && start_block;
    assign w_last   = (r_x == 3'd7) && (r_y == 3'd7);

    // Next state and Moore outputs
    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        block_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_block) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                block_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Direct 64-term summation for the current pixel (r_x, r_y).
    always_comb begin
        w_acc = '0;
        for (int u = 0; u < N; u++) begin
            for (int v = 0; v < N; v++) begin
                w_acc = w_acc + term(
                    r_coef[u][v],
                    alpha(3'(u)),
                    alpha(3'(v)),
                    cos_q8(r_x, 3'(u)),
                    cos_q8(r_y, 3'(v))
                );
            end
        end
        // Round half up, drop the 32 fraction bits, then clamp.
        w_rnd = w_acc + 60'sd2147483648;
        w_shf = w_rnd >>> 32;
        if (w_shf > 60'sd255) begin
            w_pix = 9'sd255;
        end else if (w_shf < -60'sd256) begin
            w_pix = -9'sd256;
        end else begin
            w_pix = w_shf[8:0];
        end
    end

    // Counters, coefficient latch and pixel store
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= 3'd0;
            r_y <= 3'd0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_coef[i][j] <= '0;
                    r_pix[i][j]  <= '0;
                end
            end
        end else if (w_accept) begin
            r_coef <= coef_block;
            r_x    <= 3'd0;
            r_y    <= 3'd0;
        end else if (r_state == S_CALC) begin
            // Row-major walk, y inner; both wrap to 0 after (7,7).
            r_pix[r_x][r_y] <= w_pix;
            r_y             <= r_y + 3'd1;
            if (r_y == 3'd7) begin
                r_x <= r_x + 3'd1;
            end
        end
    end

    assign pix_block_out = r_pix;

endmodule

// File: doc/idct_2d.md
Name: idct_2d

Overview:
Inverse 2-D DCT for the decoder path of the image codec. It takes one dequantized 8x8 coefficient block and produces the reconstructed, level-shifted 8x8 pixel block. It computes one output pixel per cycle by direct summation over all 64 coefficients. It is the counterpart of the forward DCT stage, with matching alpha and cosine conventions.

Parameters:
BLOCK_SIZE, 8, block edge length. Only 8 is supported; the counters, tables and widths below are sized for 8.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start_block  input  1  request to start a block; sampled only in IDLE
coef_block  input  signed 16 x [8][8]  dequantized coefficients C(u,v), Q16.0; sampled on the accepting edge only
pix_block_out  output  signed 9 x [8][8]  reconstructed pixels f(x,y), Q9.0, level-shifted
busy  output  1  high in CALC and DONE
block_done  output  1  one-cycle pulse when all 64 pixels of the block are valid

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, x=y=0, coefficient register=0, all pix_block_out=0, busy=0, block_done=0. Reset overrides everything, including mid-CALC; the partial block is discarded and no block_done is issued.
- State machine:
  - IDLE: if start_block=1, latch coef_block into an internal register, clear x/y, go to CALC.
  - CALC: counter (x,y) in row-major order, y inner, 64 cycles. Each cycle, register pixel (x,y) into pix_block_out[x][y]. At (7,7), go to DONE.
  - DONE: block_done=1 for one cycle, then go to IDLE.
- start_block is ignored in CALC and DONE; no queueing.
- Timing: accept edge is cycle 0. CALC covers cycles 1..64. Pixel (x,y) becomes visible on the edge ending its CALC cycle. block_done is high in cycle 65, when all 64 outputs are stable. If start_block is held high, blocks repeat every 66 cycles.
- Output hold: pix_block_out holds its value until overwritten pixel-by-pixel by the next block. Entries not yet rewritten keep the previous block's values.
- Math: f(x,y) = sum over u,v of a(u)·a(v)·C(u,v)·cos[x][u]·cos[y][v].
  - Alpha, Q1.8 unsigned: a(0)=91 (0x5B), a(k>0)=128 (0x80).
  - Cosine table: hardwired constant, signed 10-bit Q2.8, cos[n][k]=round(256·cos((2n+1)kπ/16)). Magnitudes are 256, 251, 237, 213, 181, 142, 98, 50 with signs per the formula. cos[n][0]=256 must be representable, hence 10 bits.
- Widths:
  - Each term is Q20.32, at least 54 bits signed.
  - The 64-term accumulator is 60 bits signed and never overflows.
  - Result: add 2^31, then arithmetic shift right by 32, i.e. round-half-up.
  - Saturate to [-256, 255] and emit as signed 9-bit.
- All arithmetic is signed; alpha is zero-extended before multiplying.
- The per-cycle datapath may be pipelined internally only if CALC still spans exactly 64 cycles and the cycle-65 block_done timing is preserved.

Test Plan:
- All-zero coef_block, start at cycle 0 -> busy high cycles 1..65; block_done only in cycle 65; all 64 pixels = 0.
- C(0,0)=1024, all others 0 -> every pixel = 129 (1024·8281/65536 = 129.39, rounded); block_done in cycle 65.
- C(0,0)=32767 -> all pixels saturate to 255. Then C(0,0)=-32768 -> all pixels = -256.
- C(0,1)=512, all others 0 -> f(x,y)=round(512·91·128·256·cos[y][1]/2^32).
  - y=0 gives round(89.22)=89; y=7 gives -89.
  - Each row is identical across x.
- start_block held high for 200 cycles -> block_done in cycles 65, 131 and 197; start_block pulses during CALC are ignored; coef_block changed mid-CALC does not affect output.
- Assert rst in cycle 30 of CALC -> next cycle all outputs are 0 and state is IDLE; no block_done. A new start after reset runs normally.
